// File: rtl/press_pkg.sv
// Shared event codes and FSM encoding for the pushbutton gesture classifier.
package press_pkg;

   localparam logic [1:0] EVT_NONE   = 2'b00;
   localparam logic [1:0] EVT_SHORT  = 2'b01;
   localparam logic [1:0] EVT_LONG   = 2'b10;
   localparam logic [1:0] EVT_DOUBLE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRESS1   = 2'd1,
      ST_GAP      = 2'd2,
      ST_REL_WAIT = 2'd3
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/press_evt_reg.sv
// Single-entry output register for classified events, with a sticky flag
// recording any event that arrived while the previous one was still unaccepted.
module press_evt_reg
   import press_pkg::*;
(
   input  logic       clk,
   input  logic       clear,
   input  logic       emit,
   input  logic [1:0] code,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   output logic       overflow
);

   logic       r_valid;
   logic [1:0] r_code;
   logic       r_overflow;
   logic       w_accept;

   // Handshake: the event held here is consumed on any edge where
   // evt_valid and evt_ready are both high; code reads 00 whenever empty.
   assign w_accept = r_valid & evt_ready;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_valid    <= 1'b0;
         r_code     <= EVT_NONE;
         r_overflow <= 1'b0;
      end else if (emit && (!r_valid || w_accept)) begin
         r_valid <= 1'b1;
         r_code  <= code;
      end else if (emit) begin
         // Register still full and not being drained: keep the old event.
         r_overflow <= 1'b1;
      end else if (w_accept) begin
         r_valid <= 1'b0;
         r_code  <= EVT_NONE;
      end
   end

   assign evt_valid = r_valid;
   assign evt_code  = r_code;
   assign overflow  = r_overflow;

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button presses as short, long or double and hands
// each gesture to the consumer as one event code.
module press_classifier
   import press_pkg::*;
#(
   parameter int LONG_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 25_000_000
)
(
   input  logic       clk,
   input  logic       clear,
   input  logic       pb_level,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   input  logic       evt_ready,
   output logic       overflow,
   output logic       busy,
   output state_t     dbg_state
);

   localparam int CNT_W = $clog2(max_int(LONG_CYCLES, GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             w_emit;
   logic [1:0]       w_code;

   // Emit is decoded from the current state and level so that a double
   // press reaches the output register on the same edge that samples it.
   always_comb begin
      w_emit = 1'b0;
      w_code = EVT_NONE;
      case (r_state)
         ST_PRESS1: begin
            if (pb_level && (r_cnt == LONG_LAST)) begin
               w_emit = 1'b1;
               w_code = EVT_LONG;
            end
         end
         ST_GAP: begin
            if (pb_level) begin
               w_emit = 1'b1;
               w_code = EVT_DOUBLE;
            end else if (r_cnt == GAP_LAST) begin
               w_emit = 1'b1;
               w_code = EVT_SHORT;
            end
         end
         default: ;
      endcase
   end

   // Reset lands in REL_WAIT so a button held through clear must be
   // released before any gesture can start.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_state <= ST_REL_WAIT;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (pb_level) begin
                  r_state <= ST_PRESS1;
                  r_cnt   <= CNT_ONE;
                  r_busy  <= 1'b1;
               end
            end
            ST_PRESS1: begin
               if (pb_level) begin
                  if (r_cnt == LONG_LAST) begin
                     r_state <= ST_REL_WAIT;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end
               end else begin
                  r_state <= ST_GAP;
                  r_cnt   <= CNT_ONE;
               end
            end
            ST_GAP: begin
               if (pb_level) begin
                  // Second press is never timed; just wait for its release.
                  r_state <= ST_REL_WAIT;
                  r_cnt   <= '0;
               end else if (r_cnt == GAP_LAST) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ST_REL_WAIT: begin
               if (!pb_level) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_REL_WAIT;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   press_evt_reg u_evt_reg (
      .clk       (clk),
      .clear     (clear),
      .emit      (w_emit),
      .code      (w_code),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .overflow  (overflow)
   );

   assign busy      = r_busy;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: button waveforms are built as runs of equal
// level and the expected events are derived from those run lengths.
module tb_press_classifier;
   import press_pkg::*;

   localparam int LONG_C = 8;
   localparam int GAP_C  = 4;

   logic       clk;
   logic       clear;
   logic       pb_level;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_ready;
   logic       overflow;
   logic       busy;
   state_t     dbg_state;

   int total;
   int bad;
   int edge_n;

   logic [1:0] exp_q[$];
   int         exp_edge[$];
   logic [1:0] obs_q[$];
   int         obs_edge[$];
   int         run_lvl[$];
   int         run_len[$];

   press_classifier #(.LONG_CYCLES(LONG_C), .GAP_CYCLES(GAP_C)) dut (
      .clk       (clk),
      .clear     (clear),
      .pb_level  (pb_level),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_ready (evt_ready),
      .overflow  (overflow),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: drive the level, take the edge, then log any held event.
   task automatic tick(input logic pb);
      pb_level = pb;
      @(posedge clk);
      edge_n++;
      #1;
      if (evt_valid) begin
         obs_q.push_back(evt_code);
         obs_edge.push_back(edge_n);
      end
   endtask

   task automatic reset_queues();
      exp_q.delete();
      exp_edge.delete();
      obs_q.delete();
      obs_edge.delete();
   endtask

   // Gesture rules over runs: a high run of LONG_C or more is long at its
   // LONG_C-th sample; a shorter one followed by GAP_C or more lows is short
   // at the GAP_C-th low; a shorter gap makes a double at the next high run.
   task automatic model_runs(input int start);
      int st[$];
      int e;
      int k;
      e = start;
      foreach (run_len[i]) begin
         st.push_back(e);
         e += run_len[i];
      end
      k = 0;
      while (k < run_len.size()) begin
         if (run_lvl[k] == 0) begin
            k++;
         end else if (run_len[k] >= LONG_C) begin
            exp_q.push_back(EVT_LONG);
            exp_edge.push_back(st[k] + LONG_C - 1);
            k++;
         end else if (k + 1 >= run_len.size()) begin
            k = run_len.size();
         end else if (run_len[k+1] >= GAP_C) begin
            exp_q.push_back(EVT_SHORT);
            exp_edge.push_back(st[k+1] + GAP_C - 1);
            k += 2;
         end else if (k + 2 < run_len.size()) begin
            exp_q.push_back(EVT_DOUBLE);
            exp_edge.push_back(st[k+2]);
            k += 3;
         end else begin
            k = run_len.size();
         end
      end
   endtask

   task automatic drive_runs();
      model_runs(edge_n + 1);
      foreach (run_len[i])
         for (int j = 0; j < run_len[i]; j++) tick(run_lvl[i] != 0);
      run_lvl.delete();
      run_len.delete();
   endtask

   task automatic add_run(input int lvl, input int len);
      run_lvl.push_back(lvl);
      run_len.push_back(len);
   endtask

   task automatic test_reset();
      reset_queues();
      clear = 1'b1;
      tick(1'b1);
      clear = 1'b0;
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", evt_valid); end
      total++; if (evt_code !== EVT_NONE) begin bad++; $display("FAIL reset_code actual=%b required=00", evt_code); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow actual=%b required=0", overflow); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy actual=%b required=1", busy); end
      total++; if (dbg_state !== ST_REL_WAIT) begin bad++; $display("FAIL reset_state actual=%0d required=%0d", dbg_state, ST_REL_WAIT); end
      for (int i = 0; i < 20; i++) tick(1'b1);
      total++; if (obs_q.size() != 0) begin bad++; $display("FAIL held_no_event actual=%0d required=0", obs_q.size()); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_busy actual=%b required=1", busy); end
      tick(1'b0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy actual=%b required=0", busy); end
   endtask

   task automatic test_short();
      int r;
      reset_queues();
      add_run(0, 1); add_run(1, 3); add_run(0, 8);
      r = edge_n + 5;
      drive_runs();
      total++; if (obs_q.size() != 1) begin bad++; $display("FAIL short_count actual=%0d required=1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         total++; if (obs_q[0] !== EVT_SHORT) begin bad++; $display("FAIL short_code actual=%b required=01", obs_q[0]); end
         total++; if (obs_edge[0] != r + GAP_C - 1) begin bad++; $display("FAIL short_edge actual=%0d required=%0d", obs_edge[0], r + GAP_C - 1); end
      end
   endtask

   task automatic test_boundary();
      reset_queues();
      add_run(0, 1); add_run(1, LONG_C - 1); add_run(0, 8);
      add_run(1, LONG_C); add_run(0, 2);
      add_run(1, LONG_C + 30); add_run(0, 8);
      drive_runs();
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL boundary_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         total++;
         if (obs_q[i] !== exp_q[i] || obs_edge[i] != exp_edge[i]) begin
            bad++; $display("FAIL boundary_evt%0d actual=%b@%0d required=%b@%0d", i, obs_q[i], obs_edge[i], exp_q[i], exp_edge[i]);
         end
      end
   endtask

   task automatic test_double();
      reset_queues();
      add_run(0, 1); add_run(1, 2); add_run(0, 2); add_run(1, 12); add_run(0, 8);
      drive_runs();
      total++; if (obs_q.size() != 1) begin bad++; $display("FAIL double_count actual=%0d required=1", obs_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         total++;
         if (obs_q[i] !== exp_q[i] || obs_edge[i] != exp_edge[i]) begin
            bad++; $display("FAIL double_evt%0d actual=%b@%0d required=%b@%0d", i, obs_q[i], obs_edge[i], exp_q[i], exp_edge[i]);
         end
      end
   endtask

   task automatic test_overflow();
      reset_queues();
      evt_ready = 1'b0;
      add_run(0, 1); add_run(1, 3); add_run(0, 8); add_run(1, LONG_C); add_run(0, 8);
      drive_runs();
      total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid actual=%b required=1", evt_valid); end
      total++; if (evt_code !== EVT_SHORT) begin bad++; $display("FAIL ovf_code actual=%b required=01", evt_code); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag actual=%b required=1", overflow); end
      evt_ready = 1'b1;
      tick(1'b0);
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain_valid actual=%b required=0", evt_valid); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky actual=%b required=1", overflow); end
      clear = 1'b1;
      tick(1'b0);
      clear = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear actual=%b required=0", overflow); end
      tick(1'b0);
   endtask

   task automatic test_reset_mid_press();
      reset_queues();
      tick(1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1);
      clear = 1'b1;
      tick(1'b1);
      clear = 1'b0;
      for (int i = 0; i < 20; i++) tick(1'b1);
      total++; if (obs_q.size() != 0) begin bad++; $display("FAIL midreset_no_event actual=%0d required=0", obs_q.size()); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy actual=%b required=1", busy); end
      reset_queues();
      add_run(0, 2); add_run(1, 3); add_run(0, 8);
      drive_runs();
      total++; if (obs_q.size() != 1) begin bad++; $display("FAIL midreset_count actual=%0d required=1", obs_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         total++;
         if (obs_q[i] !== exp_q[i] || obs_edge[i] != exp_edge[i]) begin
            bad++; $display("FAIL midreset_evt%0d actual=%b@%0d required=%b@%0d", i, obs_q[i], obs_edge[i], exp_q[i], exp_edge[i]);
         end
      end
   endtask

   task automatic test_random();
      int n;
      for (int round = 0; round < 8; round++) begin
         reset_queues();
         add_run(0, $urandom_range(1, 3));
         n = $urandom_range(2, 5);
         for (int g = 0; g < n; g++) begin
            add_run(1, $urandom_range(1, 12));
            if (g == n - 1) add_run(0, GAP_C + 2 + $urandom_range(0, 3));
            else add_run(0, $urandom_range(1, 7));
         end
         drive_runs();
         total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count actual=%0d required=%0d", round, obs_q.size(), exp_q.size()); end
         foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i] || obs_edge[i] != exp_edge[i]) begin
               bad++; $display("FAIL rand%0d_evt%0d actual=%b@%0d required=%b@%0d", round, i, obs_q[i], obs_edge[i], exp_q[i], exp_edge[i]);
            end
         end
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      edge_n    = 0;
      clear     = 1'b1;
      pb_level  = 1'b0;
      evt_ready = 1'b1;
      test_reset();
      test_short();
      test_boundary();
      test_double();
      test_overflow();
      test_reset_mid_press();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
